// File: rtl/instr_encoder.sv
// instr_encoder: turns simple instruction requests (add/sub/lw/sw/beq/addi)
// into RV32I machine words and writes them sequentially into instruction
// memory starting at BASE_ADDR, stopping once DEPTH words have been written.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   in_kind,
  input  logic [4:0]                   in_rd,
  input  logic [4:0]                   in_rs1,
  input  logic [4:0]                   in_rs2,
  input  logic [31:0]                  in_imm,
  output logic                         wr_en,
  output logic [31:0]                  wr_addr,
  output logic [31:0]                  wr_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         err,
  input  logic                         err_clr
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ENCODE = 2'd1;
  localparam logic [1:0] WRITE  = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  localparam logic [2:0] KIND_ADD  = 3'd0;
  localparam logic [2:0] KIND_SUB  = 3'd1;
  localparam logic [2:0] KIND_LW   = 3'd2;
  localparam logic [2:0] KIND_SW   = 3'd3;
  localparam logic [2:0] KIND_BEQ  = 3'd4;
  localparam logic [2:0] KIND_ADDI = 3'd5;

  logic [1:0]  state;
  logic [1:0]  stateNext;
  logic [2:0]  kindQ;
  logic [4:0]  rdQ;
  logic [4:0]  rs1Q;
  logic [4:0]  rs2Q;
  logic [31:0] immQ;
  logic        legal;
  logic [31:0] encWord;
  logic        imm12Ok;
  logic        imm13Ok;

  assign in_ready = (state == IDLE) && !full;
  assign full     = (count == CntW'(DEPTH));
  assign wr_en    = (state == WRITE);
  assign err      = (state == ERROR);

  // 12-bit signed range [-2048, 2047]: bits 31..11 are a pure sign extension.
  assign imm12Ok = (immQ[31:11] == '0) || (immQ[31:11] == '1);
  // Branch offset range [-4096, 4094], and must be even.
  assign imm13Ok = ((immQ[31:12] == '0) || (immQ[31:12] == '1)) && !immQ[0];

  // Build the instruction word from the registered request and judge legality.
  always_comb begin
    encWord = '0;
    legal   = 1'b0;
    case (kindQ)
      KIND_ADD: begin
        encWord = {7'b0000000, rs2Q, rs1Q, 3'b000, rdQ, 7'b0110011};
        legal   = 1'b1;
      end
      KIND_SUB: begin
        encWord = {7'b0100000, rs2Q, rs1Q, 3'b000, rdQ, 7'b0110011};
        legal   = 1'b1;
      end
      KIND_LW: begin
        encWord = {immQ[11:0], rs1Q, 3'b010, rdQ, 7'b0000011};
        legal   = imm12Ok;
      end
      KIND_SW: begin
        encWord = {immQ[11:5], rs2Q, rs1Q, 3'b010, immQ[4:0], 7'b0100011};
        legal   = imm12Ok;
      end
      KIND_BEQ: begin
        encWord = {immQ[12], immQ[10:5], rs2Q, rs1Q, 3'b000,
                   immQ[4:1], immQ[11], 7'b1100011};
        legal   = imm13Ok;
      end
      KIND_ADDI: begin
        encWord = {immQ[11:0], rs1Q, 3'b000, rdQ, 7'b0010011};
        legal   = imm12Ok;
      end
      default: begin
        encWord = '0;
        legal   = 1'b0;
      end
    endcase
  end

  // Next-state logic for the accept/encode/write/error sequence.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (in_valid && in_ready) stateNext = ENCODE;
      ENCODE:  stateNext = legal ? WRITE : ERROR;
      WRITE:   stateNext = IDLE;
      ERROR:   if (err_clr) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register; reset overrides everything, including err_clr.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Capture the request fields on the accepting handshake.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      kindQ <= in_kind;
      rdQ   <= in_rd;
      rs1Q  <= in_rs1;
      rs2Q  <= in_rs2;
      immQ  <= in_imm;
    end
  end

  // Load the write port on entry to WRITE; it holds between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr <= BASE_ADDR;
      wr_data <= '0;
    end else if (state == ENCODE && legal) begin
      wr_addr <= BASE_ADDR + (32'(count) << 2);
      wr_data <= encWord;
    end
  end

  // Words-written counter, bumped as WRITE completes.
  always_ff @(posedge clk) begin
    if (reset)               count <= '0;
    else if (state == WRITE) count <= count + CntW'(1);
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: one default-sized instance at address 0
// and one DEPTH=2 instance at 0x100 for the full/stall behaviour.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid [2];
  logic        errClr  [2];
  logic [2:0]  kind;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        inReady [2];
  logic        wrEn    [2];
  logic [31:0] wrAddr  [2];
  logic [31:0] wrData  [2];
  logic        full    [2];
  logic        err     [2];
  logic [6:0]  cnt0;
  logic [1:0]  cnt1;
  logic [31:0] cnt     [2];

  int total = 0;
  int bad   = 0;

  assign cnt[0] = 32'(cnt0);
  assign cnt[1] = 32'(cnt1);

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(32'h0000_0000), .DEPTH(64)) u0 (
    .clk(clk), .reset(reset), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .in_kind(kind), .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm),
    .wr_en(wrEn[0]), .wr_addr(wrAddr[0]), .wr_data(wrData[0]),
    .count(cnt0), .full(full[0]), .err(err[0]), .err_clr(errClr[0])
  );

  instr_encoder #(.BASE_ADDR(32'h0000_0100), .DEPTH(2)) u1 (
    .clk(clk), .reset(reset), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .in_kind(kind), .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm),
    .wr_en(wrEn[1]), .wr_addr(wrAddr[1]), .wr_data(wrData[1]),
    .count(cnt1), .full(full[1]), .err(err[1]), .err_clr(errClr[1])
  );

  task automatic checkVal(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request to instance d and follow it through encode and write.
  task automatic sendReq(input int d, input logic [2:0] k, input logic [4:0] rdV,
                         input logic [4:0] rs1V, input logic [4:0] rs2V,
                         input logic [31:0] immV, input bit legal,
                         input logic [31:0] expData, input logic [31:0] expAddr,
                         input logic [31:0] expCount);
    int waited;
    @(negedge clk);
    kind = k; rd = rdV; rs1 = rs1V; rs2 = rs2V; imm = immV;
    inValid[d] = 1'b1;
    waited = 0;
    while (inReady[d] !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    checkVal("acceptReady", 32'(inReady[d]), 32'd1);
    if (inReady[d] !== 1'b1) begin
      inValid[d] = 1'b0;
      return;
    end
    @(negedge clk);
    inValid[d] = 1'b0;
    checkVal("encodeNoWr", 32'(wrEn[d]), 32'd0);
    checkVal("encodeNotReady", 32'(inReady[d]), 32'd0);
    @(negedge clk);
    if (legal) begin
      checkVal("wrEn", 32'(wrEn[d]), 32'd1);
      checkVal("wrData", wrData[d], expData);
      checkVal("wrAddr", wrAddr[d], expAddr);
    end else begin
      checkVal("errNoWr", 32'(wrEn[d]), 32'd0);
      checkVal("errSet", 32'(err[d]), 32'd1);
    end
    @(negedge clk);
    checkVal("postWrEn", 32'(wrEn[d]), 32'd0);
    checkVal("count", cnt[d], expCount);
    if (legal) begin
      checkVal("holdData", wrData[d], expData);
      checkVal("holdAddr", wrAddr[d], expAddr);
    end else begin
      checkVal("errSticky", 32'(err[d]), 32'd1);
      checkVal("errNotReady", 32'(inReady[d]), 32'd0);
    end
  endtask

  task automatic clearErr(input int d);
    errClr[d] = 1'b1;
    @(negedge clk);
    errClr[d] = 1'b0;
    checkVal("errCleared", 32'(err[d]), 32'd0);
    checkVal("readyAfterClr", 32'(inReady[d]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    inValid[0] = 1'b0; inValid[1] = 1'b0;
    errClr[0]  = 1'b0; errClr[1]  = 1'b0;
    kind = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    checkVal("rstReady", 32'(inReady[0]), 32'd1);
    checkVal("rstWrEn", 32'(wrEn[0]), 32'd0);
    checkVal("rstAddr", wrAddr[0], 32'h0);
    checkVal("rstData", wrData[0], 32'h0);
    checkVal("rstCount", cnt[0], 32'd0);
    checkVal("rstFull", 32'(full[0]), 32'd0);
    checkVal("rstErr", 32'(err[0]), 32'd0);
    checkVal("rstAddrB", wrAddr[1], 32'h100);

    // R-type, loads/stores (unused register fields set to junk), branch
    sendReq(0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0,        1, 32'h002081B3, 32'h00, 32'd1);
    sendReq(0, 3'd1, 5'd3, 5'd1, 5'd2, 32'd0,        1, 32'h402081B3, 32'h04, 32'd2);
    sendReq(0, 3'd2, 5'd5, 5'd1, 5'd31, 32'd8,       1, 32'h0080A283, 32'h08, 32'd3);
    sendReq(0, 3'd3, 5'd31, 5'd1, 5'd2, 32'd12,      1, 32'h0020A623, 32'h0C, 32'd4);
    sendReq(0, 3'd4, 5'd7, 5'd1, 5'd2, -32'sd8,      1, 32'hFE208CE3, 32'h10, 32'd5);

    // Illegal requests: odd branch, addi out of range, illegal kind
    sendReq(0, 3'd4, 5'd0, 5'd1, 5'd2, 32'd3,        0, 32'h0, 32'h0, 32'd5);
    clearErr(0);
    sendReq(0, 3'd5, 5'd1, 5'd0, 5'd0, 32'd2048,     0, 32'h0, 32'h0, 32'd5);
    clearErr(0);
    sendReq(0, 3'd7, 5'd1, 5'd1, 5'd1, 32'd0,        0, 32'h0, 32'h0, 32'd5);
    clearErr(0);

    // Immediate range boundaries
    sendReq(0, 3'd5, 5'd1, 5'd0, 5'd0, -32'sd2048,   1, 32'h80000093, 32'h14, 32'd6);
    sendReq(0, 3'd5, 5'd2, 5'd1, 5'd0, 32'd2047,     1, 32'h7FF08113, 32'h18, 32'd7);
    sendReq(0, 3'd4, 5'd0, 5'd0, 5'd0, 32'd4094,     1, 32'h7E000FE3, 32'h1C, 32'd8);

    // err_clr while idle changes nothing
    @(negedge clk);
    errClr[0] = 1'b1;
    @(negedge clk);
    errClr[0] = 1'b0;
    checkVal("idleClrErr", 32'(err[0]), 32'd0);
    checkVal("idleClrReady", 32'(inReady[0]), 32'd1);
    checkVal("idleClrCount", cnt[0], 32'd8);

    // Reset the cycle after accept aborts the request
    @(negedge clk);
    kind = 3'd0; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; imm = '0;
    inValid[0] = 1'b1;
    @(negedge clk);
    inValid[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkVal("abortWrEn", 32'(wrEn[0]), 32'd0);
    checkVal("abortCount", cnt[0], 32'd0);
    checkVal("abortReady", 32'(inReady[0]), 32'd1);
    @(negedge clk);
    checkVal("abortWrEnLate", 32'(wrEn[0]), 32'd0);
    sendReq(0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0,        1, 32'h002081B3, 32'h00, 32'd1);

    // Small instance: fills after two words, then refuses further requests
    sendReq(1, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0,        1, 32'h002081B3, 32'h100, 32'd1);
    sendReq(1, 3'd1, 5'd3, 5'd1, 5'd2, 32'd0,        1, 32'h402081B3, 32'h104, 32'd2);
    checkVal("fullSet", 32'(full[1]), 32'd1);
    checkVal("fullNotReady", 32'(inReady[1]), 32'd0);
    @(negedge clk);
    inValid[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkVal("fullNoWr", 32'(wrEn[1]), 32'd0);
      checkVal("fullStillNotReady", 32'(inReady[1]), 32'd0);
    end
    inValid[1] = 1'b0;
    checkVal("fullCount", cnt[1], 32'd2);

    // Reset releases the full condition
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkVal("rstFullClr", 32'(full[1]), 32'd0);
    checkVal("rstCountB", cnt[1], 32'd0);
    checkVal("rstReadyB", 32'(inReady[1]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
